// File: rtl/wptr_full_afull_if.sv
// Write-side FIFO pointer bus: write request and synchronized read pointer in,
// memory address, Gray pointer and status flags out.
interface wptr_full_afull_if #(
   parameter int unsigned ASIZE = 4
);
   localparam int unsigned PW = ASIZE + 1;

   logic          winc;
   logic          wclr_ovf;
   logic [PW-1:0] wq2_rptr;
   logic [ASIZE-1:0] waddr;
   logic [PW-1:0] wptr;
   logic          wfull;
   logic          wafull;
   logic          woverflow;
   logic [PW-1:0] wlevel;

   // Write-domain producer side
   modport master (
      output winc, wclr_ovf, wq2_rptr,
      input  waddr, wptr, wfull, wafull, woverflow, wlevel
   );

   // Pointer/flag generator side
   modport slave (
      input  winc, wclr_ovf, wq2_rptr,
      output waddr, wptr, wfull, wafull, woverflow, wlevel
   );
endinterface

// File: rtl/wptr_full_afull.sv
// Write-domain pointer and flag generator for an asynchronous FIFO: binary/Gray
// write pointer, registered full, almost-full, fill level and sticky overflow.
module wptr_full_afull #(
   parameter int unsigned ASIZE        = 4,
   parameter int unsigned AFULL_MARGIN = 2
) (
   input logic               wclk,
   input logic               wrst,
   wptr_full_afull_if.slave  bus
);
   localparam int unsigned PW    = ASIZE + 1;
   localparam int unsigned DEPTH = 2 ** ASIZE;
   localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_MARGIN);

   logic [PW-1:0] wbin;
   logic [PW-1:0] wptr_q;
   logic          wfull_q;
   logic          wafull_q;
   logic          woverflow_q;
   logic [PW-1:0] wlevel_q;

   logic          wr_commit_c;
   logic          ovf_set_c;
   logic [PW-1:0] wbinnext_c;
   logic [PW-1:0] wgraynext_c;
   logic [PW-1:0] rbin_w_c;
   logic [PW-1:0] full_pat_c;
   logic [PW-1:0] wlevel_next_c;
   logic          wfull_val_c;
   logic          wafull_val_c;
   logic          woverflow_next_c;

   // Write qualification and next pointer values
   always_comb begin
      wr_commit_c = bus.winc & ~wfull_q;
      ovf_set_c   = bus.winc & wfull_q;
      wbinnext_c  = wbin + PW'(wr_commit_c);
      wgraynext_c = (wbinnext_c >> 1) ^ wbinnext_c;
   end

   // Gray-to-binary of the synchronized read pointer, XOR prefix from the MSB
   always_comb begin
      rbin_w_c = '0;
      rbin_w_c[PW-1] = bus.wq2_rptr[PW-1];
      for (int i = int'(PW) - 2; i >= 0; i--) begin
         rbin_w_c[i] = rbin_w_c[i+1] ^ bus.wq2_rptr[i];
      end
   end

   // Full when the next Gray pointer is one lap ahead of the read pointer
   always_comb begin
      full_pat_c    = {~bus.wq2_rptr[ASIZE:ASIZE-1], bus.wq2_rptr[ASIZE-2:0]};
      wfull_val_c   = (wgraynext_c == full_pat_c);
      wlevel_next_c = wbinnext_c - rbin_w_c;
      wafull_val_c  = (wlevel_next_c >= AFULL_LEVEL);
   end

   // Sticky overflow; a set in the same cycle as a clear takes priority
   always_comb begin
      woverflow_next_c = woverflow_q;
      if (bus.wclr_ovf) woverflow_next_c = 1'b0;
      if (ovf_set_c)    woverflow_next_c = 1'b1;
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin        <= '0;
         wptr_q      <= '0;
         wfull_q     <= 1'b0;
         wafull_q    <= 1'b0;
         woverflow_q <= 1'b0;
         wlevel_q    <= '0;
      end else begin
         wbin        <= wbinnext_c;
         wptr_q      <= wgraynext_c;
         wfull_q     <= wfull_val_c;
         wafull_q    <= wafull_val_c;
         woverflow_q <= woverflow_next_c;
         wlevel_q    <= wlevel_next_c;
      end
   end

   assign bus.waddr     = wbin[ASIZE-1:0];
   assign bus.wptr      = wptr_q;
   assign bus.wfull     = wfull_q;
   assign bus.wafull    = wafull_q;
   assign bus.woverflow = woverflow_q;
   assign bus.wlevel    = wlevel_q;

endmodule

// File: tb/tb_wptr_full_afull.sv
// Directed scoreboard bench for wptr_full_afull (ASIZE=4, AFULL_MARGIN=2).
module tb_wptr_full_afull;
   localparam int unsigned ASIZE  = 4;
   localparam int unsigned MARGIN = 2;
   localparam int unsigned DEPTH  = 2 ** ASIZE;
   localparam int unsigned PW     = ASIZE + 1;

   typedef struct {
      logic [ASIZE-1:0] waddr;
      logic [PW-1:0]    wptr;
      logic             wfull;
      logic             wafull;
      logic             woverflow;
      logic [PW-1:0]    wlevel;
   } exp_t;

   logic wclk = 1'b0;
   logic wrst;
   int   n_assert = 0;
   int   n_fail   = 0;

   exp_t sb_q[$];

   // Reference model state
   int   m_wbin;
   int   m_level;
   logic m_full;
   logic m_afull;
   logic m_ovf;
   logic [PW-1:0] prev_wptr;
   logic have_prev = 1'b0;

   wptr_full_afull_if #(.ASIZE(ASIZE)) bus ();

   wptr_full_afull #(.ASIZE(ASIZE), .AFULL_MARGIN(MARGIN)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   always #5 wclk = ~wclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int g2b(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int s = 1; s < int'(PW); s++) b = b ^ (g >> s);
      return int'(b);
   endfunction

   function automatic logic [PW-1:0] b2g(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: model, push expectation, drive, edge, pop and compare
   task automatic step(input logic inc, input logic clr, input logic [PW-1:0] rg, input logic rst);
      exp_t e;
      exp_t got;
      int   rb;
      logic commit;
      logic ovf_set;
      if (rst) begin
         m_wbin = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      end else begin
         commit  = inc && !m_full;
         ovf_set = inc && m_full;
         m_wbin  = (m_wbin + (commit ? 1 : 0)) % (2 * DEPTH);
         rb      = g2b(rg);
         m_level = (m_wbin - rb + 2 * DEPTH) % (2 * DEPTH);
         m_full  = (m_level == DEPTH);
         m_afull = (m_level >= DEPTH - MARGIN);
         m_ovf   = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
      end
      e.waddr     = ASIZE'(m_wbin);
      e.wptr      = b2g(m_wbin);
      e.wfull     = m_full;
      e.wafull    = m_afull;
      e.woverflow = m_ovf;
      e.wlevel    = PW'(m_level);
      sb_q.push_back(e);

      bus.winc     = inc;
      bus.wclr_ovf = clr;
      bus.wq2_rptr = rg;
      wrst         = rst;
      @(posedge wclk);
      #1;

      got = sb_q.pop_front();
      check("waddr",     32'(bus.waddr),     32'(got.waddr));
      check("wptr",      32'(bus.wptr),      32'(got.wptr));
      check("wfull",     32'(bus.wfull),     32'(got.wfull));
      check("wafull",    32'(bus.wafull),    32'(got.wafull));
      check("woverflow", 32'(bus.woverflow), 32'(got.woverflow));
      check("wlevel",    32'(bus.wlevel),    32'(got.wlevel));
      check("inv_level_le_depth", 32'(bus.wlevel <= PW'(DEPTH)), 32'(1));
      check("inv_full_level", 32'(!bus.wfull || (bus.wlevel == PW'(DEPTH))), 32'(1));
      if (have_prev && !rst)
         check("inv_gray_1bit", 32'($countones(bus.wptr ^ prev_wptr) <= 1), 32'(1));
      prev_wptr = bus.wptr;
      have_prev = 1'b1;
   endtask

   initial begin
      bus.winc = 1'b0; bus.wclr_ovf = 1'b0; bus.wq2_rptr = '0; wrst = 1'b1;

      // Reset then idle
      step(1'b0, 1'b0, 5'h00, 1'b1);
      step(1'b0, 1'b0, 5'h00, 1'b1);
      step(1'b0, 1'b0, 5'h00, 1'b0);
      check("idle_wlevel", 32'(bus.wlevel), 32'd0);
      check("idle_waddr",  32'(bus.waddr),  32'd0);

      // Fill from empty
      for (int i = 0; i < 16; i++) begin
         check("fill_waddr", 32'(bus.waddr), 32'(i));
         step(1'b1, 1'b0, 5'h00, 1'b0);
         if (i == 12) check("afull_before_14", 32'(bus.wafull), 32'd0);
         if (i == 13) begin
            check("afull_at_14", 32'(bus.wafull), 32'd1);
            check("level_at_14", 32'(bus.wlevel), 32'd14);
         end
      end
      check("full_at_16",  32'(bus.wfull),  32'd1);
      check("wptr_at_16",  32'(bus.wptr),   32'h18);
      check("level_at_16", 32'(bus.wlevel), 32'd16);
      check("waddr_wrap",  32'(bus.waddr),  32'd0);

      // Overflow set / clear / set-wins
      step(1'b1, 1'b0, 5'h00, 1'b0);
      check("ovf_wptr_hold", 32'(bus.wptr),      32'h18);
      check("ovf_set",       32'(bus.woverflow), 32'd1);
      step(1'b0, 1'b1, 5'h00, 1'b0);
      check("ovf_clr",       32'(bus.woverflow), 32'd0);
      step(1'b1, 1'b1, 5'h00, 1'b0);
      check("ovf_set_wins",  32'(bus.woverflow), 32'd1);

      // Read drain and wrap
      step(1'b0, 1'b0, 5'h0C, 1'b0);
      check("drain_full",  32'(bus.wfull),  32'd0);
      check("drain_afull", 32'(bus.wafull), 32'd0);
      check("drain_level", 32'(bus.wlevel), 32'd8);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'h0C, 1'b0);
      check("wrap_waddr", 32'(bus.waddr),  32'd8);
      check("wrap_wptr",  32'(bus.wptr),   32'h14);
      check("wrap_full",  32'(bus.wfull),  32'd1);
      check("wrap_level", 32'(bus.wlevel), 32'd16);

      // Reset mid-operation drops the in-flight write
      step(1'b0, 1'b0, 5'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'h00, 1'b0);
      step(1'b1, 1'b0, 5'h00, 1'b1);
      check("midrst_wptr",  32'(bus.wptr),      32'd0);
      check("midrst_full",  32'(bus.wfull),     32'd0);
      check("midrst_level", 32'(bus.wlevel),    32'd0);
      check("midrst_ovf",   32'(bus.woverflow), 32'd0);
      step(1'b0, 1'b0, 5'h00, 1'b0);
      check("midrst_waddr", 32'(bus.waddr), 32'd0);

      // Simultaneous write and read advance at level 15
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 5'h00, 1'b0);
      check("sim_pre_level", 32'(bus.wlevel), 32'd15);
      step(1'b1, 1'b0, 5'h01, 1'b0);
      check("sim_level", 32'(bus.wlevel), 32'd15);
      check("sim_full",  32'(bus.wfull),  32'd0);
      check("sim_afull", 32'(bus.wafull), 32'd1);

      // Continue around the ring with a moving read pointer
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b2g(2 + i / 2), 1'b0);
      end

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
